// File: rtl/uart_tx_scheduler.sv
// UART transmit sequencer: small TX FIFO feeding a start/data/parity/stop shifter,
// paced by an external baud tick and gating that generator through bps_en.
`timescale 1ns/1ps
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       bps_tick,
  output logic       bps_en,
  output logic       txd,
  output logic       busy,
  output logic [4:0] fifo_count,
  output logic       tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_PAR   = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  function automatic logic f_parity_bit(input logic [7:0] d);
    if (PARITY == 2) begin
      f_parity_bit = ^d;
    end else begin
      f_parity_bit = ~^d;
    end
  endfunction

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_count;
  logic          r_wr_ready;
  state_t        r_state;
  logic [7:0]    r_shreg;
  logic [2:0]    r_idx;
  logic          r_stop_cnt;
  logic          r_txd;
  logic          r_bps_en;
  logic          r_tx_done;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [2:0]    w_idx_nxt;
  logic          w_stop_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic          w_txd_nxt;
  logic [4:0]    w_count_nxt;

  assign w_push = wr_valid & r_wr_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 5'd1;
      2'b01:   w_count_nxt = r_count - 5'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // wr_ready is registered from the next count, so it never depends on pop combinationally
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= 5'd0;
      r_wr_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count    <= w_count_nxt;
      r_wr_ready <= (w_count_nxt != DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_stop_nxt  = r_stop_cnt;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != 5'd0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      // the generator's first tick after enable is a half period late; ARM swallows it
      S_ARM: begin
        if (bps_tick) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (bps_tick) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (bps_tick) begin
          if (r_idx == 3'd7) begin
            w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            w_stop_nxt  = 1'b0;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      S_PAR: begin
        if (bps_tick) begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
        end
      end
      S_STOP: begin
        if (bps_tick) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_done = 1'b1;
            if (r_count != 5'd0) begin
              w_pop       = 1'b1;
              w_state_nxt = S_START;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_stop_nxt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_txd_nxt = 1'b1;
    case (r_state)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = r_shreg[r_idx];
      S_PAR:   w_txd_nxt = f_parity_bit(r_shreg);
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // txd lags the state by one clock; bps_en and busy follow the next state
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shreg    <= 8'd0;
      r_idx      <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_bps_en   <= 1'b0;
      r_tx_done  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_cnt <= w_stop_nxt;
      if (w_pop) begin
        r_shreg <= r_mem[r_rptr];
      end
      r_txd      <= w_txd_nxt;
      r_bps_en   <= (w_state_nxt != S_IDLE);
      r_tx_done  <= w_done;
      r_busy     <= (w_state_nxt != S_IDLE) | (w_count_nxt != 5'd0);
    end
  end

  assign wr_ready   = r_wr_ready;
  assign bps_en     = r_bps_en;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign tx_done    = r_tx_done;

endmodule
